macrow_fir: RTL and testbench

Parametrised successor of the fixed 4-lane MAC row. It is a transposed-form chain of N_TAP signed fixed-point multiply-accumulate taps fed by a broadcast sample stream, with runtime coefficient loading. It adds a valid/ready handshake on both sides, a warm-up counter, a synchronous flush, and optional output saturation. It sits between the sample source and the downstream accumulator/writeback stage.

---
 rtl/macrow_pkg.sv | 37 +++
 rtl/macrow_tap.sv | 42 ++++
 rtl/macrow_fir.sv | 109 ++++++++++
 tb/tb_macrow_fir.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/macrow_pkg.sv
// Shared widths, warm-up state type and the signed narrowing helper for the macrow_fir slice.
package macrow_pkg;

  typedef enum logic [0:0] {StWarm, StRun} state_e;

  localparam int unsigned MaxW = 64;

  function automatic int unsigned calc_aw(input int unsigned n_tap);
    return $clog2(n_tap);
  endfunction

  function automatic int unsigned calc_acc_w(input int unsigned n_tap, input int unsigned data_w);
    return 2 * data_w + $clog2(n_tap);
  endfunction

  // Clamp a sign-extended value to the signed out_w range, flagging when it clipped.
  function automatic logic signed [MaxW-1:0] sat_narrow(input logic signed [MaxW-1:0] val,
                                                        input int unsigned out_w,
                                                        output logic clipped);
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    logic signed [MaxW-1:0] res;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    res     = val;
    clipped = 1'b0;
    if (val > hi) begin
      res     = hi;
      clipped = 1'b1;
    end else if (val < lo) begin
      res     = lo;
      clipped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/macrow_tap.sv
// One transposed-form tap: a coefficient register and a partial-sum register.
module macrow_tap #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned AW     = 2,
  parameter int unsigned INDEX  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     accept,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [ACC_W-1:0]  sum_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [DATA_W-1:0]   w_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod  = x_i * w_q;
  assign sum_o = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      // Coefficient writes are honoured even during a flush.
      if (w_we && (w_addr == AW'(INDEX))) w_q <= w_i;
      if (clr) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= sum_i + ACC_W'(prod);
      end
    end
  end

endmodule

// File: rtl/macrow_fir.sv
// Parametrised transposed-form FIR row with valid/ready handshake, warm-up and flush.
// Optional output saturation is enabled by defining MACROW_SAT_EN.
module macrow_fir
  import macrow_pkg::*;
#(
  parameter int unsigned N_TAP  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 16,
  localparam int unsigned ACC_W = calc_acc_w(N_TAP, DATA_W),
  localparam int unsigned AW    = calc_aw(N_TAP)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y_o,
  output logic                     sat_o
);

  localparam int unsigned CntW = $clog2(N_TAP + 1);

  logic                    accept;
  logic [CntW-1:0]         cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] chain [N_TAP];
  logic signed [ACC_W-1:0] acc_last;

  assign in_ready  = !clr && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < N_TAP; i++) begin : g_tap
    logic signed [ACC_W-1:0] sum_in;
    if (i == 0) begin : g_first
      assign sum_in = '0;
    end else begin : g_rest
      assign sum_in = chain[i-1];
    end
    macrow_tap #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .AW    (AW),
      .INDEX (i)
    ) u_tap (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .accept(accept),
      .w_we  (w_we),
      .w_addr(w_addr),
      .w_i   (w_i),
      .x_i   (x_i),
      .sum_i (sum_in),
      .sum_o (chain[i])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (accept && (state_q == StWarm)) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntW'(N_TAP)) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q       <= '0;
      state_q     <= StWarm;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (accept && (state_d == StRun)) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // The last tap's register only moves on accept and clears on flush, so it doubles as
  // the output register: y_o and sat_o hold through backpressure.
  assign acc_last = chain[N_TAP-1];

`ifdef MACROW_SAT_EN
  logic signed [MaxW-1:0] y_wide;
  logic                   clipped;
  always_comb begin
    clipped = 1'b0;
    y_wide  = sat_narrow(MaxW'(acc_last), OUT_W, clipped);
  end
  assign y_o   = OUT_W'(y_wide);
  assign sat_o = clipped;
`else
  assign y_o   = OUT_W'(acc_last);
  assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_macrow_fir.sv
// Directed self-checking bench for macrow_fir with N_TAP=4, DATA_W=8, OUT_W=16.
module tb_macrow_fir;

  logic              clk = 1'b0;
  logic              reset;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_i;
  logic              w_we;
  logic [1:0]        w_addr;
  logic signed [7:0] w_i;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] y_o;
  logic              sat_o;

  int n_tests = 0;
  int n_fail  = 0;

  macrow_fir #(
    .N_TAP (4),
    .DATA_W(8),
    .OUT_W (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_i      (x_i),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_i      (w_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_o      (y_o),
    .sat_o    (sat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    in_valid  = 1'b1;
    x_i       = 8'(x);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = 2'(addr);
    w_i    = 8'(val);
    tick();
    w_we = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    x_i       = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_i       = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state and zero coefficients
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y_o), 0);
    chk("rst_sat", int'(sat_o), 0);
    for (int i = 0; i < 4; i++) send(3 + i);
    chk("w0_out_valid", int'(out_valid), 1);
    chk("w0_y", int'(y_o), 0);

    // Back-to-back stream with W = {1,2,3,4}
    flush();
    for (int i = 0; i < 4; i++) wr(i, i + 1);
    for (int i = 1; i <= 3; i++) begin
      send(i);
      chk("b2b_warm_valid", int'(out_valid), 0);
    end
    send(4);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_y30", int'(y_o), 30);
    send(5);
    chk("b2b_y40", int'(y_o), 40);

    // Same stream with random idle gaps
    flush();
    for (int i = 1; i <= 5; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        if (i <= 4) chk("gap_idle_valid", int'(out_valid), 0);
      end
      send(i);
      if (i < 4) chk("gap_warm_valid", int'(out_valid), 0);
      if (i == 4) chk("gap_y30", int'(y_o), 30);
      if (i == 5) chk("gap_y40", int'(y_o), 40);
    end

    // Backpressure stall after y = 30
    flush();
    for (int i = 1; i <= 4; i++) send(i);
    chk("bp_y30", int'(y_o), 30);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_i       = 8'sd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
      chk("bp_hold_y", int'(y_o), 30);
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_y40", int'(y_o), 40);
    tick();
    chk("bp_drain_valid", int'(out_valid), 0);

    // Overflow: all coefficients and samples 127
    flush();
    for (int i = 0; i < 4; i++) wr(i, 127);
    for (int i = 0; i < 4; i++) send(127);
    chk("ovf_valid", int'(out_valid), 1);
`ifdef MACROW_SAT_EN
    chk("ovf_y", int'(y_o), 32767);
    chk("ovf_sat", int'(sat_o), 1);
`else
    chk("ovf_y", int'(y_o), -1020);
    chk("ovf_sat", int'(sat_o), 0);
`endif

    // Flush mid-warm-up together with a coefficient write
    flush();
    for (int i = 0; i < 4; i++) wr(i, i + 1);
    send(7);
    send(9);
    clr      = 1'b1;
    w_we     = 1'b1;
    w_addr   = 2'd0;
    w_i      = 8'sd5;
    in_valid = 1'b1;
    x_i      = 8'sd1;
    #1;
    chk("clr_in_ready", int'(in_ready), 0);
    tick();
    clr      = 1'b0;
    w_we     = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_y", int'(y_o), 0);
    for (int i = 0; i < 3; i++) begin
      send(1);
      chk("clr_warm_valid", int'(out_valid), 0);
    end
    send(1);
    chk("clr_valid4", int'(out_valid), 1);
    chk("clr_y14", int'(y_o), 14);

    // Write coinciding with an accept takes effect on the following sample
    in_valid  = 1'b1;
    x_i       = 8'sd1;
    out_ready = 1'b1;
    w_we      = 1'b1;
    w_addr    = 2'd3;
    w_i       = 8'sd10;
    tick();
    in_valid = 1'b0;
    w_we     = 1'b0;
    chk("wacc_old_w", int'(y_o), 14);
    send(1);
    chk("wacc_new_w", int'(y_o), 20);

    // Reset clears coefficients too
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid", int'(out_valid), 0);
    chk("rst2_y", int'(y_o), 0);
    for (int i = 0; i < 4; i++) send(5);
    chk("rst2_w_cleared", int'(y_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
